// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parameterized register file.
package regfile_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps registers 1..NREGS-1 to zero after reset or on
// clr_req, and reports ready once the file is back in RUN.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= FIRST;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // idx parks at LAST once in RUN, so it can never wrap to 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ready     = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (idx == LAST) state_nxt = RUN;
        else             idx_nxt   = idx + FIRST;
      end
      RUN: begin
        ready = 1'b1;
        if (clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = FIRST;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign clr_idx = idx;

endmodule

// File: rtl/regfile_param.sv
// Two-read/one-write register file with hardwired zero register and a
// zeroing sweep after reset or clr_req. Optional write-to-read bypass is
// enabled by defining REGFILE_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              clr_req,
  output logic              ready
);

  localparam int NREGS = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              usr_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem [NREGS];

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // A user write racing a clear request is dropped; the sweep owns the port.
  assign usr_we  = ready & we & (wa != '0) & ~clr_req;
  assign wr_en   = clr_we | usr_we;
  assign wr_addr = clr_we ? clr_idx : wa;
  assign wr_data = clr_we ? '0 : wd;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][DATA_W-1:0] rd;

  assign ra = {ra2, ra1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd[p] = '0;
      if (ready && ra[p] != '0) begin
        rd[p] = mem[ra[p]];
`ifdef REGFILE_BYPASS_EN
        if (usr_we && ra[p] == wa) rd[p] = wd;
`endif
      end
    end
  end

  assign rd1 = rd[0];
  assign rd2 = rd[1];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default-size instance plus a
// DATA_W=16/ADDR_W=3 instance; honours REGFILE_BYPASS_EN for expectations.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic        we, clr_req, ready;

  logic        rst_s;
  logic [2:0]  ra1_s, ra2_s, wa_s;
  logic [15:0] rd1_s, rd2_s, wd_s;
  logic        we_s, clr_s, ready_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .clr_req(clr_req), .ready(ready)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3)) dut_s (
    .clk(clk), .rst_n(rst_s), .ra1(ra1_s), .ra2(ra2_s), .rd1(rd1_s), .rd2(rd2_s),
    .we(we_s), .wa(wa_s), .wd(wd_s), .clr_req(clr_s), .ready(ready_s)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk n sweep cycles expecting ready=0 and rd1=0, optionally pulsing
  // clr_req at cycle clr_at, then expect ready=1.
  task automatic sweep_chk(input string nm, input int n, input int clr_at);
    for (int c = 0; c < n; c++) begin
      clr_req = (c == clr_at);
      chk({nm, " ready low"}, {31'd0, ready}, 32'd0);
      chk({nm, " rd1 zero"}, rd1, 32'd0);
      tick();
    end
    clr_req = 1'b0;
    chk({nm, " ready high"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    tv[0] = '{1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5,
              BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0};
    tv[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h12345678, 32'h12345678};
    tv[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0, 32'h12345678};
    tv[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 32'h0, 32'hDEADBEEF};
    tv[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5,
              BYP ? 32'hA5A5A5A5 : 32'h0, 32'h12345678};
    tv[5] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tv[6] = '{1'b1, 5'd7, 32'h00001111, 5'd7, 5'd3,
              BYP ? 32'h00001111 : 32'hA5A5A5A5, 32'hDEADBEEF};
    tv[7] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 32'h00001111, 32'h0};

    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd3; ra2 = 5'd0; clr_req = 1'b0;
    rst_s = 1'b0; we_s = 1'b0; wa_s = '0; wd_s = '0; ra1_s = '0; ra2_s = '0; clr_s = 1'b0;

    repeat (3) tick();
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset rd1", rd1, 32'd0);
    chk("reset rd2", rd2, 32'd0);

    // Write held through the post-reset sweep lands on the first RUN edge.
    we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
    rst_n = 1'b1;
    sweep_chk("boot sweep", 31, -1);
    chk("first run rd1", rd1, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    we = 1'b0;
    chk("held write landed", rd1, 32'hDEADBEEF);

    for (int i = 0; i < 8; i++) begin
      we = tv[i].we; wa = tv[i].wa; wd = tv[i].wd; ra1 = tv[i].ra1; ra2 = tv[i].ra2;
      #1;
      chk($sformatf("vec%0d rd1", i), rd1, tv[i].e1);
      chk($sformatf("vec%0d rd2", i), rd2, tv[i].e2);
      chk($sformatf("vec%0d ready", i), {31'd0, ready}, 32'd1);
      tick();
    end
    we = 1'b0;

    // Fill, then clear with a racing write and an ignored second request.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i);
      tick();
    end
    we = 1'b0; ra1 = 5'd9; ra2 = 5'd31;
    #1;
    chk("fill reg9", rd1, 32'd9);
    chk("fill reg31", rd2, 32'd31);
    clr_req = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h99;
    #1;
    chk("ready before clear", {31'd0, ready}, 32'd1);
    tick();
    clr_req = 1'b0; we = 1'b0; ra1 = 5'd9;
    sweep_chk("clr sweep", 31, 10);
    begin
      int nz = 0;
      for (int i = 0; i < 32; i++) begin
        ra1 = 5'(i); ra2 = 5'(31 - i);
        #1;
        if (rd1 != 32'd0 || rd2 != 32'd0) nz++;
      end
      chk("regs zero after clear", 32'(nz), 32'd0);
    end

    // Async reset in RUN, then reset mid-sweep restarts a full sweep.
    we = 1'b1; wa = 5'd4; wd = 32'h44;
    tick();
    we = 1'b0; ra1 = 5'd4;
    #1;
    chk("reg4 written", rd1, 32'h44);
    #1 rst_n = 1'b0;
    #1;
    chk("async ready drop", {31'd0, ready}, 32'd0);
    chk("rd1 in reset", rd1, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    chk("mid sweep ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep_chk("restart sweep", 31, -1);
    ra1 = 5'd4;
    #1;
    chk("reg4 cleared", rd1, 32'd0);

    // Small instance: 7-cycle sweep, top address usable, no idx wrap.
    rst_s = 1'b1;
    for (int r = 0; r < 2; r++) begin
      int lo = 0;
      for (int c = 0; c < 7; c++) begin
        if (ready_s) lo++;
        tick();
        clr_s = 1'b0;
      end
      chk($sformatf("small sweep%0d early ready", r), 32'(lo), 32'd0);
      chk($sformatf("small sweep%0d ready", r), {31'd0, ready_s}, 32'd1);
      if (r == 0) begin
        we_s = 1'b1; wa_s = 3'd7; wd_s = 16'hBEEF;
        tick();
        we_s = 1'b0; ra1_s = 3'd7; ra2_s = 3'd6;
        repeat (10) tick();
        chk("small rd1 addr7", {16'd0, rd1_s}, 32'h0000BEEF);
        chk("small rd2 addr6", {16'd0, rd2_s}, 32'd0);
        chk("small stays ready", {31'd0, ready_s}, 32'd1);
        clr_s = 1'b1;
        tick();
      end
    end
    chk("small addr7 cleared", {16'd0, rd1_s}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
